line_arbiter: RTL
=================

Name: line_arbiter

Overview:
- Shares the single cacheline adaptor / physical-memory port between the instruction cache and the data cache.
- Sits between the two caches' 256-bit line-side interfaces and the adaptor's line_i/line_o/read_i/write_i/address_i/resp_o port.
- Grants one requester at a time, latches its command, forwards it downstream, and routes the adaptor's completion pulse back to the granted cache only.
- Arbitration is round-robin by default, or fixed data-cache priority by parameter.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, line address width.
- FIXED_PRIO, 0, 0 = round-robin between I and D; 1 = D-cache always wins on simultaneous requests.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_read  input  1  I-cache line read request, held until i_resp.
- i_address  input  ADDR_W  I-cache line address.
- i_rdata  output  LINE_W  line data returned to I-cache.
- i_resp  output  1  one-cycle completion pulse to I-cache.
- d_read  input  1  D-cache line read request, held until d_resp.
- d_write  input  1  D-cache line writeback request, held until d_resp.
- d_address  input  ADDR_W  D-cache line address.
- d_wdata  input  LINE_W  D-cache writeback line.
- d_rdata  output  LINE_W  line data returned to D-cache.
- d_resp  output  1  one-cycle completion pulse to D-cache.
- mem_read  output  1  to adaptor read_i.
- mem_write  output  1  to adaptor write_i.
- mem_address  output  ADDR_W  to adaptor address_i.
- mem_wdata  output  LINE_W  to adaptor line_i.
- mem_rdata  input  LINE_W  from adaptor line_o.
- mem_resp  input  1  from adaptor resp_o, one-cycle pulse.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - mem_read, mem_write, i_resp and d_resp go to 0.
  - mem_address and mem_wdata go to 0.
  - last_grant goes to D, so the first simultaneous round-robin contest goes to I.
- States are IDLE, SERVE_I and SERVE_D. A 1-bit last_grant register is also kept.
- IDLE:
  - Drives mem_read = mem_write = 0.
  - Samples requests each cycle: req_i = i_read; req_d = d_read | d_write.
  - Only req_i: go to SERVE_I. Only req_d: go to SERVE_D.
  - Both, FIXED_PRIO = 1: go to SERVE_D.
  - Both, FIXED_PRIO = 0: serve the requester that is not last_grant.
  - On the transition edge, register the granted address (and d_wdata for D) into mem_address/mem_wdata and set last_grant.
- Grant latency: a request first visible in IDLE at cycle N gives mem_read/mem_write high from cycle N+1.
- mem_address and mem_wdata are registered at grant and stay stable for the whole transaction, independent of later requester input changes.
- SERVE_I:
  - mem_read = 1, mem_write = 0.
  - i_resp = mem_resp, combinational in the same cycle. d_resp = 0.
  - On mem_resp, return to IDLE at the next edge.
- SERVE_D:
  - mem_write = d_write latched at grant; mem_read = ~mem_write.
  - d_resp = mem_resp, combinational. i_resp = 0.
  - On mem_resp, return to IDLE.
- Read data: i_rdata and d_rdata are both wired to mem_rdata. Caches may only consume it on their own resp.
- Back-to-back transactions:
  - IDLE is always spent for at least one cycle between transactions, so there is minimum one cycle of mem_read/mem_write low between transactions.
  - A requester that deasserted on its resp edge is never re-granted spuriously.
- d_read and d_write both high at grant: the write is served. This is a protocol violation and is flagged by bench assertion.
- A request that drops before resp while in a SERVE state is ignored. The transaction completes downstream and resp is still pulsed.
- mem_resp while in IDLE is ignored: no resp is forwarded and the state does not change.
- Reset mid-transaction aborts immediately to IDLE. The adaptor shares reset_n, so no downstream cleanup is needed.
- Outputs i_resp and d_resp are never high in the same cycle.

Test Plan:
1. I-only read at 0x0000_1000, adaptor responds 4 cycles after mem_read: mem_read rises one cycle after i_read, mem_address = 0x0000_1000, i_resp pulses with mem_resp, i_rdata = the adaptor line, d_resp stays 0.
2. D writeback to 0x0000_2040 with d_wdata = {8{32'hDEADBEEF}}: mem_write = 1, mem_read = 0, mem_wdata matches, d_resp pulses once, state returns to IDLE next cycle.
3. FIXED_PRIO = 0, i_read and d_read asserted together from reset: I is served first, then D after one IDLE cycle. A repeat contest alternates D then I.
4. FIXED_PRIO = 1, simultaneous requests held continuously: D is always granted while d_read stays high. I is granted only once D drops.
5. reset_n pulled low mid-SERVE_D, before mem_resp: mem_write drops asynchronously and no d_resp is issued. After release, a pending i_read is granted within 1 cycle.
6. Spurious mem_resp in IDLE, plus i_address changed during SERVE_I: no resp is forwarded, and mem_address holds the value latched at grant.

Source files
------------

// File: rtl/line_arbiter.sv
// line_arbiter: shares one cacheline adaptor port between the I-cache and D-cache.
// One requester is granted at a time; its command is latched at grant and the
// adaptor completion pulse is steered back to the granted cache only.
module line_arbiter #(
    parameter int unsigned LINE_W     = 256,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    // I-cache line side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // D-cache line side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // adaptor side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              last_grant_nxt;
    logic              mem_read_nxt;
    logic              mem_write_nxt;
    logic [ADDR_W-1:0] mem_address_nxt;
    logic [LINE_W-1:0] mem_wdata_nxt;
    logic              req_i;
    logic              req_d;
    logic              grant_d;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    // Read data is broadcast; each cache only consumes it on its own resp.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // State, grant history and latched downstream command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= GRANT_D;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            mem_read    <= mem_read_nxt;
            mem_write   <= mem_write_nxt;
            mem_address <= mem_address_nxt;
            mem_wdata   <= mem_wdata_nxt;
        end
    end

    // Arbitration, next-state and completion steering.
    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        mem_read_nxt    = mem_read;
        mem_write_nxt   = mem_write;
        mem_address_nxt = mem_address;
        mem_wdata_nxt   = mem_wdata;
        grant_d         = 1'b0;
        i_resp          = 1'b0;
        d_resp          = 1'b0;

        case (state)
            IDLE: begin
                mem_read_nxt  = 1'b0;
                mem_write_nxt = 1'b0;
                if (req_i && req_d) begin
                    grant_d = (FIXED_PRIO != 0) ? 1'b1 : (last_grant == GRANT_I);
                end else begin
                    grant_d = req_d;
                end
                if (req_i || req_d) begin
                    if (grant_d) begin
                        // A simultaneous read+write is resolved as a write.
                        state_nxt       = SERVE_D;
                        last_grant_nxt  = GRANT_D;
                        mem_address_nxt = d_address;
                        mem_wdata_nxt   = d_wdata;
                        mem_write_nxt   = d_write;
                        mem_read_nxt    = ~d_write;
                    end else begin
                        state_nxt       = SERVE_I;
                        last_grant_nxt  = GRANT_I;
                        mem_address_nxt = i_address;
                        mem_read_nxt    = 1'b1;
                        mem_write_nxt   = 1'b0;
                    end
                end
            end
            SERVE_I: begin
                i_resp = mem_resp;
                if (mem_resp) begin
                    state_nxt     = IDLE;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                end
            end
            SERVE_D: begin
                d_resp = mem_resp;
                if (mem_resp) begin
                    state_nxt     = IDLE;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                mem_read_nxt  = 1'b0;
                mem_write_nxt = 1'b0;
            end
        endcase
    end

endmodule
